// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one instruction word at the address held in
// the external PC, presents it downstream and steps the PC. A branch or jump
// redirect reloads the PC, and any fetch already in flight is discarded.
//
// Handshakes: both interfaces use valid/ready semantics. A transfer happens
// on a rising clk edge where the source's valid and the sink's ready are both
// 1: mem_req/mem_ack for the memory read, ir_valid/ir_ready for the
// downstream. mem_req and mem_addr, and ir_valid, ir_out and ir_pc, stay
// stable until their transfer completes. A redirect can withdraw ir_valid
// without a transfer.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [15:0] pc_load_val,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir_out,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state;

    assign state_dbg   = state;
    assign pc_load_val = redirect_addr;

    // PC control: redirect wins over increment, and both stay quiet in reset.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (reset) begin
            pc_load = redirect;
            pc_inc  = !redirect && (state == FETCH) && mem_ack;
        end
    end

    // Fetch sequencer with registered memory and instruction outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
            ir_out   <= 16'h0000;
            ir_pc    <= 16'h0000;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A redirect here just lets the PC take the new target first.
                    if (!redirect) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_in;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        if (mem_ack) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            // The read cannot be cancelled, so wait it out.
                            state <= FLUSH;
                        end
                    end else if (mem_ack) begin
                        state    <= HOLD;
                        mem_req  <= 1'b0;
                        ir_out   <= mem_rdata;
                        ir_pc    <= mem_addr;
                        ir_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        // A same-cycle ir_ready has still taken the instruction.
                        state    <= IDLE;
                        ir_valid <= 1'b0;
                    end else if (ir_ready) begin
                        state    <= FETCH;
                        ir_valid <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_in;
                    end
                end
                FLUSH: begin
                    // Stale data is dropped; further redirects only retarget the PC.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: external PC and memory models, random downstream and
// redirect traffic, and a queue-based scoreboard of the instruction stream.
module tb_fetch_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] pc;
    logic        pc_inc, pc_load;
    logic [15:0] pc_load_val;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out, ir_pc;
    logic        ir_valid, ir_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [1:0]  state_dbg;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .state_dbg(state_dbg)
    );

    // Stimulus knobs, written only by the main sequence.
    int lat_min, lat_max, ready_pct, redir_pct;
    bit force_quiet, fast_chk;
    logic        pc_set_en;
    logic [15:0] pc_set_val;

    int checks = 0;
    int failures = 0;
    int deliveries = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd257;
        return t + 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- environment models ----------------
    // PC register: load has priority, then increment; 16-bit wrap.
    always @(posedge clk) begin
        if (pc_set_en) pc <= pc_set_val;
        else if (pc_load) pc <= pc_load_val;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    // ---------------- driver tasks ----------------
    int  wait_n = 0;
    bit  busy = 0;

    task automatic drive_memory();
        if (!reset || !mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            busy      = 0;
        end else begin
            if (!busy) begin
                busy   = 1;
                wait_n = $urandom_range(lat_max, lat_min);
            end
            if (wait_n == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                busy      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_n--;
            end
        end
    endtask

    task automatic drive_downstream();
        ir_ready = ($urandom_range(99, 0) < ready_pct);
        redirect = force_quiet ? 1'b0 : ($urandom_range(99, 0) < redir_pct);
        redirect_addr = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
    endtask

    always @(posedge clk) begin
        #1;
        drive_memory();
        drive_downstream();
    end

    // ---------------- scoreboard / monitor ----------------
    // Each entry is {pc, instruction} of the next instruction to be delivered.
    logic [31:0] exp_q[$];
    bit          seeded = 0;
    bit          have_prev = 0;
    logic        prev_mem_req, prev_stall;
    logic [15:0] prev_mem_addr, prev_ir_out, prev_ir_pc;
    int          cyc = 0;
    int          last_acc = 0;
    bit          last_acc_fast = 0;
    int          idle_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [15:0] np;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            seeded    = 0;
            have_prev = 0;
            idle_cnt  = 0;
            last_acc_fast = 0;
        end else begin
            if (!seeded) begin
                exp_q.push_back({pc, mem_fn(pc)});
                seeded = 1;
            end
            chk("pc_load_follows_redirect", {31'd0, pc_load}, {31'd0, redirect});
            if (redirect) chk("pc_load_val", {16'd0, pc_load_val}, {16'd0, redirect_addr});
            if (pc_inc && pc_load) chk("inc_load_exclusive", 32'd1, 32'd0);
            if (have_prev && prev_mem_req && mem_req)
                chk("mem_addr_stable", {16'd0, mem_addr}, {16'd0, prev_mem_addr});
            if (have_prev && prev_stall) begin
                chk("hold_ir_valid", {31'd0, ir_valid}, 32'd1);
                chk("hold_ir_out", {16'd0, ir_out}, {16'd0, prev_ir_out});
                chk("hold_ir_pc", {16'd0, ir_pc}, {16'd0, prev_ir_pc});
                chk("hold_no_mem_req", {31'd0, mem_req}, 32'd0);
                chk("hold_no_pc_inc", {31'd0, pc_inc}, 32'd0);
            end
            if (ir_valid && ir_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ir_pc", {16'd0, ir_pc}, {16'd0, e[31:16]});
                    chk("ir_out", {16'd0, ir_out}, {16'd0, e[15:0]});
                    np = e[31:16] + 16'd1;
                    exp_q.push_back({np, mem_fn(np)});
                end
                if (fast_chk && last_acc_fast)
                    chk("throughput_gap", cyc - last_acc, 32'd2);
                last_acc      = cyc;
                last_acc_fast = fast_chk;
                deliveries++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt > 200) begin
                    chk("delivery_timeout", 32'd1, 32'd0);
                    idle_cnt = 0;
                end
            end
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back({redirect_addr, mem_fn(redirect_addr)});
            end
            have_prev     = 1;
            prev_mem_req  = mem_req;
            prev_mem_addr = mem_addr;
            prev_ir_out   = ir_out;
            prev_ir_pc    = ir_pc;
            prev_stall    = ir_valid && !ir_ready && !redirect;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_ir_out"}, {16'd0, ir_out}, 32'd0);
        chk({tag, "_ir_pc"}, {16'd0, ir_pc}, 32'd0);
        chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
        chk({tag, "_pc_inc"}, {31'd0, pc_inc}, 32'd0);
        chk({tag, "_pc_load"}, {31'd0, pc_load}, 32'd0);
        chk({tag, "_state_idle"}, {30'd0, state_dbg}, 32'd0);
    endtask

    // Release reset with the PC preset to v; the first fetch must follow one
    // cycle later at address v.
    task automatic release_and_check(input logic [15:0] v);
        @(posedge clk);
        #1;
        pc_set_en = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("release_idle_cycle", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
        chk("first_fetch_addr", {16'd0, mem_addr}, {16'd0, v});
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        bit found;
        reset = 1'b0;
        pc_set_en = 1'b1; pc_set_val = 16'h0000;
        force_quiet = 1; fast_chk = 0;
        lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
        mem_ack = 1'b0; mem_rdata = 16'h0000; ir_ready = 1'b0;
        redirect = 1'b0; redirect_addr = 16'h0000;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_and_check(16'h0000);

        // Ack one cycle after request, always ready: 0, 1, 2, ...
        repeat (20) @(negedge clk);

        // Immediate ack and ready: one instruction every two cycles.
        lat_max = 0; lat_min = 0;
        fast_chk = 1;
        repeat (30) @(negedge clk);
        fast_chk = 0;

        // Downstream stall in HOLD.
        ready_pct = 0;
        repeat (10) @(negedge clk);
        ready_pct = 100;
        repeat (5) @(negedge clk);

        // Random latency, backpressure and redirects.
        lat_min = 0; lat_max = 3; ready_pct = 60; redir_pct = 15; force_quiet = 0;
        repeat (500) @(negedge clk);

        // Asynchronous reset in the middle of an outstanding read.
        force_quiet = 1; redir_pct = 0; lat_min = 2; lat_max = 3;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        chk("found_fetch_for_reset", {31'd0, found}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        pc_set_val = 16'hFFFE;
        pc_set_en  = 1'b1;
        repeat (2) @(negedge clk);
        release_and_check(16'hFFFE);

        // Run across the 16'hFFFF -> 16'h0000 wrap.
        lat_min = 0; lat_max = 2; ready_pct = 70;
        repeat (40) @(negedge clk);

        // Mixed random traffic again.
        lat_min = 0; lat_max = 3; ready_pct = 50; redir_pct = 10; force_quiet = 0;
        repeat (600) @(negedge clk);
        force_quiet = 1;
        repeat (5) @(negedge clk);

        chk("enough_deliveries", {31'd0, deliveries >= 100}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
